c7b_biu_dmem_resp: RTL
======================

# c7b_biu_dmem_resp

Responder (memory side) of the core's LSU↔BIU data interface: accepts one read or one write request at a time and answers with the ack / data-valid / write-done handshake the LSU expects. Backed by an on-chip byte-writable 64-bit SRAM. Used as the data-memory model in core-level simulation and as the tightly-coupled data RAM in small FPGA builds. Sits directly on the core's `lsu_biu_*` / `biu_lsu_*` ports.

## Interface
- `AW`, default 12: log2 of SRAM depth in 64-bit dwords (4096 dwords = 32 KiB).
- `RD_LAT`, default 2, legal 1..7: cycles from read ack to `biu_lsu_data_valid`.
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `lsu_biu_rd_req`  in  1  read request; held high until acked.
- `lsu_biu_rd_addr`  in  32  byte address of the read.
- `biu_lsu_rd_ack`  out  1  one-cycle read-accept pulse.
- `biu_lsu_data_valid`  out  1  one-cycle read-data pulse.
- `biu_lsu_data`  out  64  read dword; valid only while `data_valid` is high, otherwise 0.
- `lsu_biu_wr_req`  in  1  write request; held high until acked.
- `lsu_biu_wr_addr`  in  32  byte address of the write.
- `lsu_biu_wr_data`  in  64  write dword (lane-aligned).
- `lsu_biu_wr_strb`  in  8  byte enables; bit i covers `wr_data[8i+7:8i]`.
- `biu_lsu_wr_ack`  out  1  one-cycle write-accept pulse.
- `biu_lsu_write_done`  out  1  one-cycle write-complete pulse.
- `biu_err`  out  1  sticky range error; present only with `C7B_BIU_RESP_RANGECHK_EN`.

## Operation
- Dword index = `addr[AW+2:3]`; `addr[2:0]` is ignored. Reads always return the full dword. The LSU extracts the lanes it needs.
- FSM states: IDLE, RD_WAIT, WR_DONE.
- IDLE with `wr_req`=1: assert `wr_ack` combinationally in the same cycle. Addr/data/strb are written to the SRAM at that edge. Go to WR_DONE.
- IDLE with only `rd_req`=1: assert `rd_ack` combinationally. Addr is captured and the SRAM is read at that edge. Load the latency counter with `RD_LAT-1`. Go to RD_WAIT.
- IDLE with both requests high: the write wins. The read stays pending (its req is still held) and is acked in the first IDLE cycle after the write completes.
- RD_WAIT: the counter decrements each cycle. When the counter is 0, pulse `data_valid` with the registered dword and return to IDLE.
- WR_DONE: pulse `write_done` for one cycle and return to IDLE.
- Acks are issued only in IDLE, so exactly one transaction is outstanding. Requests raised in any non-IDLE state wait.
- Read-after-write to the same dword returns the new data, because the write commits before any later read is acked.
- Reset: the state goes to IDLE, the counter to 0, and every output to 0 (`biu_lsu_data`=0, `biu_err`=0). A read or write-done in flight is squashed with no pulse. SRAM contents are not cleared.

## Timing
- Read: req seen at cycle T → `rd_ack` at T, `data_valid` at T+RD_LAT. RD_LAT=1 gives data in the cycle after the ack.
- Write: req seen at T → `wr_ack` at T, `write_done` at T+1.
- Back-to-back: the next ack can be issued at the cycle after `data_valid` or `write_done`. Read throughput is 1 per RD_LAT+1 cycles; write throughput is 1 per 2 cycles.
- Ack outputs are combinational from req and state. Data, valid and done outputs are registered.

## Configuration
- `C7B_BIU_RESP_RANGECHK_EN` defined: an access with `addr[31:AW+3]` ≠ 0 is out of range.
  - An out-of-range read returns 64'hDEADBEEF_DEADBEEF.
  - An out-of-range write is dropped, but ack and done still pulse.
  - `biu_err` sets on either case and clears only on reset.
- Macro undefined: upper address bits are ignored (the address wraps/aliases) and the `biu_err` port is absent.

## Structure
- Shared defs file `c7bbiu/rtl/c7bbiu_defs.v`: FSM state encodings, the 64'hDEADBEEF_DEADBEEF poison constant, and default AW/RD_LAT.
- Sub-module `c7b_biu_sram`: single-port 2^AW×64 RAM with 8 byte-write enables and registered read. Instantiated once.

## Test plan
- Write 0x1122334455667788 to 0x100 with strb 0xFF, then read 0x104 → `wr_ack` at T and `write_done` at T+1; read data 0x1122334455667788 arrives RD_LAT cycles after `rd_ack`.
- Partial write to 0x100 with strb 0x0F and data 0xAAAAAAAA_BBBBBBBB, then read → 0x11223344BBBBBBBB.
- `rd_req` and `wr_req` raised together to the same dword → `wr_ack` first; `rd_ack` at the cycle after `write_done`; the read returns the new data.
- Assert `reset` during RD_WAIT → no `data_valid` pulse, all outputs 0; the next read is acked normally with the correct data.
- With RANGECHK: read 0x8000_0000 → 0xDEADBEEFDEADBEEF and `biu_err`=1. Without RANGECHK at AW=12: a write to 0x8000 aliases to 0x0, so a read of 0x0 returns the written data.

Source files
------------

// File: rtl/c7b_biu_dmem_resp_pkg.sv
// Shared definitions for the LSU-facing data-memory responder: FSM states,
// out-of-range poison value and default geometry.
package c7b_biu_dmem_resp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_WR_DONE = 2'd2
  } state_e;

  localparam logic [63:0] POISON_DWORD   = 64'hDEAD_BEEF_DEAD_BEEF;
  localparam int          AW_DEFAULT     = 12;
  localparam int          RD_LAT_DEFAULT = 2;

  // Counter preload so that data_valid lands exactly rd_lat cycles after the ack.
  function automatic logic [2:0] lat_preload(input int rd_lat);
    return 3'(rd_lat - 1);
  endfunction

endpackage

// File: rtl/c7b_biu_dmem_resp_sram.sv
// Single-port 2^AW x 64 SRAM with per-byte write enables and a registered read port.
module c7b_biu_sram #(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [63:0]   wdata,
  input  logic [7:0]    strb,
  output logic [63:0]   rdata
);

  logic [63:0] mem [2**AW];

  // NOTE: the array and the read register have no reset; contents must survive
  // a core reset and a reset term would stop the tools mapping this onto block RAM.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 8; i++) begin
          if (strb[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/c7b_biu_dmem_resp.sv
// LSU<->BIU data-memory responder: one read or write outstanding, write wins ties.
// Optional address range checking and sticky biu_err with C7B_BIU_RESP_RANGECHK_EN.
module c7b_biu_dmem_resp
  import c7b_biu_dmem_resp_pkg::*;
#(
  parameter int AW     = AW_DEFAULT,
  parameter int RD_LAT = RD_LAT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        lsu_biu_rd_req,
  input  logic [31:0] lsu_biu_rd_addr,
  output logic        biu_lsu_rd_ack,
  output logic        biu_lsu_data_valid,
  output logic [63:0] biu_lsu_data,
  input  logic        lsu_biu_wr_req,
  input  logic [31:0] lsu_biu_wr_addr,
  input  logic [63:0] lsu_biu_wr_data,
  input  logic [7:0]  lsu_biu_wr_strb,
  output logic        biu_lsu_wr_ack,
  output logic        biu_lsu_write_done
`ifdef C7B_BIU_RESP_RANGECHK_EN
  ,
  output logic        biu_err
`endif
);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        valid_q, done_q;
  logic        rd_ack, wr_ack;
  logic        rd_oor, wr_oor;
  logic        sram_we;
  logic [AW-1:0] rd_idx, wr_idx, sram_addr;
  logic [63:0] sram_rdata;
  logic        unused_addr_bits;

  assign rd_idx = lsu_biu_rd_addr[AW+2:3];
  assign wr_idx = lsu_biu_wr_addr[AW+2:3];

`ifdef C7B_BIU_RESP_RANGECHK_EN
  assign rd_oor = (lsu_biu_rd_addr >> (AW + 3)) != 32'd0;
  assign wr_oor = (lsu_biu_wr_addr >> (AW + 3)) != 32'd0;
  assign unused_addr_bits = ^{lsu_biu_rd_addr[2:0], lsu_biu_wr_addr[2:0]};
`else
  // Upper address bits alias onto the array.
  assign rd_oor = 1'b0;
  assign wr_oor = 1'b0;
  assign unused_addr_bits = ^{lsu_biu_rd_addr[31:AW+3], lsu_biu_rd_addr[2:0],
                              lsu_biu_wr_addr[31:AW+3], lsu_biu_wr_addr[2:0]};
`endif

  // NOTE: every always_comb output gets a default before the case so no path
  // leaves a signal unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_ack  = 1'b0;
    wr_ack  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!reset) begin
          if (lsu_biu_wr_req) begin
            wr_ack  = 1'b1;
            state_d = ST_WR_DONE;
          end else if (lsu_biu_rd_req) begin
            rd_ack  = 1'b1;
            cnt_d   = lat_preload(RD_LAT);
            state_d = ST_RD_WAIT;
          end
        end
      end
      ST_RD_WAIT: begin
        if (cnt_q == 3'd0) state_d = ST_IDLE;
        else               cnt_d   = cnt_q - 3'd1;
      end
      ST_WR_DONE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // Valid/done are decoded one cycle early so they leave the block registered.
      valid_q <= (state_d == ST_RD_WAIT) && (cnt_d == 3'd0);
      done_q  <= (state_d == ST_WR_DONE);
    end
  end

  assign sram_we   = wr_ack & ~wr_oor;
  assign sram_addr = wr_ack ? wr_idx : rd_idx;

  c7b_biu_sram #(.AW(AW)) u_sram (
    .clk   (clk),
    .en    (sram_we | rd_ack),
    .we    (sram_we),
    .addr  (sram_addr),
    .wdata (lsu_biu_wr_data),
    .strb  (lsu_biu_wr_strb),
    .rdata (sram_rdata)
  );

  assign biu_lsu_rd_ack     = rd_ack;
  assign biu_lsu_wr_ack     = wr_ack;
  assign biu_lsu_data_valid = valid_q;
  assign biu_lsu_write_done = done_q;

`ifdef C7B_BIU_RESP_RANGECHK_EN
  logic rd_oor_q, err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_oor_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (rd_ack) rd_oor_q <= rd_oor;
      if ((rd_ack && rd_oor) || (wr_ack && wr_oor)) err_q <= 1'b1;
    end
  end

  assign biu_lsu_data = !valid_q ? 64'd0 : (rd_oor_q ? POISON_DWORD : sram_rdata);
  assign biu_err      = err_q;
`else
  assign biu_lsu_data = valid_q ? sram_rdata : 64'd0;
`endif

endmodule
